// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle controller and the datapath: state codes, opcodes and
// mux/ALU select values.
package unidade_controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } estado_t;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluSrcBReg      = 2'b00;
  localparam logic [1:0] AluSrcBFour     = 2'b01;
  localparam logic [1:0] AluSrcBImm      = 2'b10;
  localparam logic [1:0] AluSrcBImmShift = 2'b11;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // 2'b11 is a reserved mux input and is never selected.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus from the multicycle controller (master) to the datapath (slave).
interface unidade_controle_multiciclo_if;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    output reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    input pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    input reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

endinterface

// File: rtl/unidade_controle_multiciclo_decodificador_saidas.sv
// Moore output decode: maps the current state to every datapath control, purely combinational.
module decodificador_saidas
  import unidade_controle_multiciclo_pkg::*;
(
  input  estado_t                              estado,
  unidade_controle_multiciclo_if.master        ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (estado)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = AluSrcBFour;
        c.alu_op    = AluOpAdd;
        c.pc_source = PcSrcAlu;
      end
      // Precompute the branch target while the instruction is decoded.
      StDecode: begin
        c.alu_src_b = AluSrcBImmShift;
        c.alu_op    = AluOpAdd;
      end
      StMemAddr, StAddiExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = AluSrcBImm;
        c.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = AluSrcBReg;
        c.alu_op    = AluOpFunct;
      end
      StRWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = AluSrcBReg;
        c.alu_op        = AluOpSub;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = PcSrcJump;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl.pc_write      = c.pc_write;
  assign ctrl.pc_write_cond = c.pc_write_cond;
  assign ctrl.i_or_d        = c.i_or_d;
  assign ctrl.mem_read      = c.mem_read;
  assign ctrl.mem_write     = c.mem_write;
  assign ctrl.ir_write      = c.ir_write;
  assign ctrl.mem_to_reg    = c.mem_to_reg;
  assign ctrl.reg_dst       = c.reg_dst;
  assign ctrl.reg_write     = c.reg_write;
  assign ctrl.alu_src_a     = c.alu_src_a;
  assign ctrl.alu_src_b     = c.alu_src_b;
  assign ctrl.alu_op        = c.alu_op;
  assign ctrl.pc_source     = c.pc_source;

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control unit: state register and next-state logic, with the output decode
// delegated to decodificador_saidas.
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] estado
);

  estado_t state_q, state_d;

  unidade_controle_multiciclo_if ctrl_bus ();

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // opcode is only looked at in DECODE and MEM_ADDR; illegal codes fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  decodificador_saidas u_decodificador_saidas (
    .estado (state_q),
    .ctrl   (ctrl_bus)
  );

  assign pc_write      = ctrl_bus.pc_write;
  assign pc_write_cond = ctrl_bus.pc_write_cond;
  assign i_or_d        = ctrl_bus.i_or_d;
  assign mem_read      = ctrl_bus.mem_read;
  assign mem_write     = ctrl_bus.mem_write;
  assign ir_write      = ctrl_bus.ir_write;
  assign mem_to_reg    = ctrl_bus.mem_to_reg;
  assign reg_dst       = ctrl_bus.reg_dst;
  assign reg_write     = ctrl_bus.reg_write;
  assign alu_src_a     = ctrl_bus.alu_src_a;
  assign alu_src_b     = ctrl_bus.alu_src_b;
  assign alu_op        = ctrl_bus.alu_op;
  assign pc_source     = ctrl_bus.pc_source;
  assign estado        = state_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle controller: walks every instruction class, async reset,
// an illegal state code and opcode changes outside the sampling states.
module tb_unidade_controle_multiciclo;
  import unidade_controle_multiciclo_pkg::*;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic [3:0] estado;
  logic [15:0] ctrl_vec;

  int checks;
  int errors;

  // Hand-computed control words, bit order:
  // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write
  // alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
  logic [15:0] exp_ctrl [0:11];

  unidade_controle_multiciclo_if bus ();

  unidade_controle_multiciclo dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .pc_write      (bus.pc_write),
    .pc_write_cond (bus.pc_write_cond),
    .i_or_d        (bus.i_or_d),
    .mem_read      (bus.mem_read),
    .mem_write     (bus.mem_write),
    .ir_write      (bus.ir_write),
    .mem_to_reg    (bus.mem_to_reg),
    .reg_dst       (bus.reg_dst),
    .reg_write     (bus.reg_write),
    .alu_src_a     (bus.alu_src_a),
    .alu_src_b     (bus.alu_src_b),
    .alu_op        (bus.alu_op),
    .pc_source     (bus.pc_source),
    .estado        (estado)
  );

  assign ctrl_vec = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.pc_source};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic expect_state(input int st);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("estado->%0d", st), 32'(estado), 32'(st));
    check($sformatf("ctrl@%0d", st), 32'(ctrl_vec), 32'(exp_ctrl[st]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ctrl[0]  = 16'h9410;
    exp_ctrl[1]  = 16'h0030;
    exp_ctrl[2]  = 16'h0060;
    exp_ctrl[3]  = 16'h3000;
    exp_ctrl[4]  = 16'h0280;
    exp_ctrl[5]  = 16'h2800;
    exp_ctrl[6]  = 16'h0048;
    exp_ctrl[7]  = 16'h0180;
    exp_ctrl[8]  = 16'h4045;
    exp_ctrl[9]  = 16'h8002;
    exp_ctrl[10] = 16'h0060;
    exp_ctrl[11] = 16'h0080;

    opcode = 6'b111111;
    reset  = 1'b1;
    #3;
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_ctrl", 32'(ctrl_vec), 32'h9410);
    @(negedge clock);
    @(negedge clock);
    check("reset_hold_estado", 32'(estado), 32'd0);
    reset = 1'b0;

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    expect_state(1); expect_state(2); expect_state(3); expect_state(4); expect_state(0);

    // sw: 0,1,2,5,0
    opcode = 6'b101011;
    expect_state(1); expect_state(2); expect_state(5); expect_state(0);

    // R-type, with opcode changed while in R_EXEC
    opcode = 6'b000000;
    expect_state(1); expect_state(6);
    opcode = 6'b100011;
    expect_state(7); expect_state(0);

    // beq, j, addi
    opcode = 6'b000100;
    expect_state(1); expect_state(8); expect_state(0);
    opcode = 6'b000010;
    expect_state(1); expect_state(9); expect_state(0);
    opcode = 6'b001000;
    expect_state(1); expect_state(10); expect_state(11); expect_state(0);

    // unknown opcode is dropped after DECODE
    opcode = 6'b111111;
    expect_state(1); expect_state(0);

    // async reset in MEM_READ, between edges
    opcode = 6'b100011;
    expect_state(1); expect_state(2); expect_state(3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_estado", 32'(estado), 32'd0);
    check("async_reset_ctrl", 32'(ctrl_vec), 32'h9410);
    @(negedge clock);
    reset = 1'b0;
    check("post_reset_estado", 32'(estado), 32'd0);
    expect_state(1);
    opcode = 6'b111111;
    expect_state(0);

    // illegal state code
    force dut.state_q = estado_t'(4'd13);
    #1;
    check("illegal_estado", 32'(estado), 32'd13);
    check("illegal_ctrl", 32'(ctrl_vec), 32'h0000);
    release dut.state_q;
    #1;
    expect_state(0);
    expect_state(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
